// File: rtl/tree_fanout_node.sv
// tree_fanout_node: hierarchy node that fans one upstream request out to masked children,
// in parallel or one at a time, collects their dones under a watchdog and acks upstream.
module tree_fanout_node #(
  parameter int NUM_CHILDREN   = 5,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    up_req,
  output logic                    up_ack,
  output logic                    up_err,
  input  logic [NUM_CHILDREN-1:0] child_mask,
  input  logic                    seq_mode,
  output logic [NUM_CHILDREN-1:0] dn_req,
  input  logic [NUM_CHILDREN-1:0] dn_done,
  output logic                    busy,
  output logic [CNT_W-1:0]        done_count
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t                  r_state;
  logic [NUM_CHILDREN-1:0] r_pend, r_dn;
  logic                    r_seq, r_ack, r_err, r_busy;
  logic [TW-1:0]           r_timer;
  logic [CNT_W-1:0]        r_cnt;
  logic [NUM_CHILDREN-1:0] w_hit, w_left, w_low_pend, w_low_left;
  logic                    w_tmo;
  assign w_hit      = r_dn & dn_done;
  assign w_left     = r_pend & ~w_hit;
  assign w_low_pend = r_pend & (-r_pend);
  assign w_low_left = w_left & (-w_left);
  assign w_tmo      = r_timer == TW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_pend  <= '0;
      r_dn    <= '0;
      r_seq   <= 1'b0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
      r_timer <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_ack <= 1'b0;
          r_err <= 1'b0;
          if (up_req) begin
            r_pend <= child_mask;
            r_seq  <= seq_mode;
            r_busy <= 1'b1;
            if (child_mask == '0) begin
              r_state <= RESP;
              r_ack   <= 1'b1;
              r_cnt   <= r_cnt + CNT_W'(1);
            end else r_state <= ISSUE;
          end
        end
        ISSUE: begin
          r_dn    <= r_seq ? w_low_pend : r_pend;
          r_timer <= '0;
          r_state <= WAIT;
        end
        WAIT: begin
          r_pend <= w_left;
          // a done in the final watchdog cycle is honoured before the timeout
          if (w_left == '0) begin
            r_dn    <= '0;
            r_ack   <= 1'b1;
            r_cnt   <= r_cnt + CNT_W'(1);
            r_state <= RESP;
          end else if (r_seq && |w_hit) begin
            r_dn    <= w_low_left;
            r_timer <= '0;
          end else if (w_tmo) begin
            r_dn    <= '0;
            r_pend  <= '0;
            r_err   <= 1'b1;
            r_ack   <= 1'b1;
            r_state <= RESP;
          end else begin
            r_dn    <= r_dn & ~w_hit;
            r_timer <= r_timer + TW'(1);
          end
        end
        RESP: begin
          r_ack   <= 1'b0;
          r_err   <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign up_ack     = r_ack;
  assign up_err     = r_err;
  assign dn_req     = r_dn;
  assign busy       = r_busy;
  assign done_count = r_cnt;
endmodule

// File: tb/tb_tree_fanout_node.sv
// tb_tree_fanout_node: directed stimulus with a queue-based ack scoreboard for tree_fanout_node.
module tb_tree_fanout_node;
  localparam int N = 5, T = 12, CW = 2;
  logic clk = 1'b0, rst = 1'b1, up_req = 1'b0, seq_mode = 1'b0;
  logic [N-1:0] child_mask = '0, dn_done = '0;
  logic up_ack, up_err, busy;
  logic [N-1:0] dn_req;
  logic [CW-1:0] done_count;
  always #5 clk = ~clk;
  tree_fanout_node #(.NUM_CHILDREN(N), .TIMEOUT_CYCLES(T), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .up_req(up_req), .up_ack(up_ack), .up_err(up_err),
    .child_mask(child_mask), .seq_mode(seq_mode), .dn_req(dn_req), .dn_done(dn_done),
    .busy(busy), .done_count(done_count)
  );
  typedef struct packed {logic err; logic [CW-1:0] cnt;} exp_t;
  exp_t sb[$];
  exp_t e;
  int n_cmp = 0, n_bad = 0;
  logic [N-1:0] sched [0:31], exp_dn [0:31];
  logic chk_dn [0:31], exp_busy [0:31], chk_busy [0:31];
  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (up_ack === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_ack: got ack at %0t expected none", $time);
      end else begin
        e = sb.pop_front();
        check("ack_err", 8'(up_err), 8'(e.err));
        check("ack_count", 8'(done_count), 8'(e.cnt));
      end
    end
  end
  task automatic clr();
    for (int i = 0; i < 32; i++) begin
      sched[i] = '0; exp_dn[i] = '0; chk_dn[i] = 1'b0; exp_busy[i] = 1'b0; chk_busy[i] = 1'b0;
    end
  endtask
  task automatic edn(input int c, input logic [N-1:0] v);
    chk_dn[c] = 1'b1; exp_dn[c] = v;
  endtask
  task automatic ebz(input int c, input logic v);
    chk_busy[c] = 1'b1; exp_busy[c] = v;
  endtask
  task automatic push(input logic err, input logic [CW-1:0] cnt);
    sb.push_back('{err: err, cnt: cnt});
  endtask
  task automatic run(input logic [N-1:0] m, input logic md, input int req_last, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      up_req = (c <= req_last); child_mask = m; seq_mode = md; dn_done = sched[c];
      @(negedge clk);
      if (chk_dn[c]) check($sformatf("dn_req@%0d", c), 8'(dn_req), 8'(exp_dn[c]));
      if (chk_busy[c]) check($sformatf("busy@%0d", c), 8'(busy), 8'(exp_busy[c]));
      @(posedge clk); #1;
    end
    up_req = 1'b0; dn_done = '0;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_dn_req", 8'(dn_req), 8'h0);
    check("rst_busy", 8'(busy), 8'h0);
    check("rst_ack", 8'(up_ack), 8'h0);
    check("rst_count", 8'(done_count), 8'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    // parallel, with a spurious done on unmasked child 1
    clr();
    sched[3] = 5'b00010; sched[4] = 5'b00001; sched[6] = 5'b00100; sched[9] = 5'b10000;
    edn(2, 5'b10101); edn(4, 5'b10101); edn(5, 5'b10100); edn(7, 5'b10000); edn(9, 5'b10000); edn(10, 5'b00000);
    ebz(10, 1'b1); ebz(11, 1'b0);
    push(1'b0, 2'd1);
    run(5'b10101, 1'b0, 0, 13);
    // sequential handoffs
    clr();
    sched[4] = 5'b00010; sched[7] = 5'b01000; sched[10] = 5'b10000;
    edn(2, 5'b00010); edn(4, 5'b00010); edn(5, 5'b01000); edn(7, 5'b01000); edn(8, 5'b10000); edn(10, 5'b10000); edn(11, 5'b00000);
    push(1'b0, 2'd2);
    run(5'b11010, 1'b1, 0, 14);
    // timeout, no done
    clr();
    edn(2, 5'b00001); edn(13, 5'b00001); edn(14, 5'b00000);
    ebz(14, 1'b1); ebz(15, 1'b0);
    push(1'b1, 2'd2);
    run(5'b00001, 1'b0, 0, 17);
    // done in the last watchdog cycle wins
    clr();
    sched[13] = 5'b00001;
    edn(13, 5'b00001); edn(14, 5'b00000);
    push(1'b0, 2'd3);
    run(5'b00001, 1'b0, 0, 16);
    // empty mask, spurious dones, counter wraps to 0
    clr();
    sched[0] = 5'b01000; sched[1] = 5'b01000; sched[2] = 5'b01000;
    edn(1, 5'b00000); ebz(1, 1'b1); ebz(2, 1'b0);
    push(1'b0, 2'd0);
    run(5'b00000, 1'b0, 0, 4);
    // reset mid-WAIT
    clr();
    edn(2, 5'b00111); edn(3, 5'b00111);
    run(5'b00111, 1'b0, 0, 4);
    rst = 1'b1;
    #1;
    check("abort_dn_req", 8'(dn_req), 8'h0);
    check("abort_busy", 8'(busy), 8'h0);
    check("abort_ack", 8'(up_ack), 8'h0);
    check("abort_err", 8'(up_err), 8'h0);
    check("abort_count", 8'(done_count), 8'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    clr();
    sched[3] = 5'b00100;
    edn(2, 5'b00100); edn(4, 5'b00000); ebz(5, 1'b0);
    push(1'b0, 2'd1);
    run(5'b00100, 1'b0, 0, 6);
    // up_req held through busy: exactly one follow-on transaction
    clr();
    sched[2] = 5'b00001; sched[6] = 5'b00001;
    edn(2, 5'b00001); edn(3, 5'b00000); edn(6, 5'b00001); edn(7, 5'b00000);
    ebz(3, 1'b1); ebz(4, 1'b0); ebz(5, 1'b1); ebz(8, 1'b0); ebz(9, 1'b0);
    push(1'b0, 2'd2); push(1'b0, 2'd3);
    run(5'b00001, 1'b0, 4, 11);
    repeat (3) @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL missing_ack: got %0d outstanding expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/tree_fanout_node.md
# tree_fanout_node

Parametrised hierarchy node controller: accepts one upstream request, distributes it to up to NUM_CHILDREN child instances (all at once or one at a time), collects their done responses, enforces a watchdog timeout, and returns a single acknowledge with an error flag. It is the generalised successor of the fixed five-child root/sub-module nodes. Instances chain into trees: a node's upstream port connects to a parent's dn_req/dn_done pair.

## Interface
- NUM_CHILDREN, 5, number of downstream child channels (1..32)
- TIMEOUT_CYCLES, 255, watchdog limit in cycles per wait window (>=2)
- CNT_W, 8, width of completed-transaction counter
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- up_req  in  1  upstream request, level; sampled only in IDLE
- up_ack  out  1  one-cycle completion pulse to upstream
- up_err  out  1  valid with up_ack; 1 = timeout occurred
- child_mask  in  NUM_CHILDREN  1 = child participates; sampled with up_req
- seq_mode  in  1  0 = parallel broadcast, 1 = sequential ascending index; sampled with up_req
- dn_req  out  NUM_CHILDREN  per-child request, level, held until that child's done
- dn_done  in  NUM_CHILDREN  per-child done pulse/level
- busy  out  1  high in any state other than IDLE
- done_count  out  CNT_W  count of error-free completed transactions, wraps

## Operation
- Reset: state IDLE; dn_req=0, up_ack=0, up_err=0, busy=0, done_count=0, internal mask/pending/timer cleared. Reset mid-transaction aborts immediately, no ack issued.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: on up_req=1, latch child_mask into pending vector and seq_mode. If latched mask is all-zero, go RESP (up_err=0). Otherwise go ISSUE.
- ISSUE (one cycle, registers outputs): parallel -> dn_req = pending; sequential -> dn_req = one-hot lowest set bit of pending. Timer cleared. Go WAIT.
- WAIT parallel: for each i with dn_req[i]=1 and dn_done[i]=1, clear pending[i] and dn_req[i] next cycle. When pending becomes zero, go RESP.
- WAIT sequential: when active child's dn_done=1, clear its pending bit and dn_req; if further pending bits remain, issue next-lowest child the following cycle (direct WAIT->WAIT with timer cleared, no ISSUE bubble); else go RESP.
- dn_done on a child with dn_req=0 is ignored.
- Timer: increments each WAIT cycle; if timer==TIMEOUT_CYCLES-1 and the cycle does not complete the current window (all remaining in parallel; active child in sequential), drop all dn_req, set up_err=1, go RESP. A done arriving in that same cycle wins: it is processed normally; error only if work still outstanding.
- RESP: up_ack=1 for exactly one cycle, up_err valid same cycle; if up_err=0 done_count increments (wrap at 2^CNT_W). Next state IDLE; up_err returns to 0.
- up_req while busy is ignored, not queued. up_req held high through RESP starts a new transaction on the first IDLE cycle.

## Timing
- up_req sampled cycle 0 -> ISSUE cycle 1 -> dn_req high from cycle 2.
- Last required dn_done at cycle k -> dn_req low at k+1, up_ack at k+1 (RESP), busy low at k+2.
- Empty mask: up_req cycle 0 -> up_ack cycle 1, busy high only cycle 1.
- Sequential handoff: done of child i at cycle k -> dn_req[i] low and next child dn_req high both at k+1.
- Timeout with no done: dn_req high cycles 2..TIMEOUT_CYCLES+1, up_ack+up_err at TIMEOUT_CYCLES+2.
- All outputs registered; no combinational input-to-output path.

## Test plan
- Parallel, mask=5'b10101, children done at cycles 4,6,9 -> dn_req bits drop at 5,7,10; up_ack=1,up_err=0 at 10; done_count 0->1.
- Sequential, mask=5'b11010, each child done 2 cycles after its req -> dn_req order 00010,01000,10000 with single-cycle handoffs; one up_ack, err=0.
- TIMEOUT_CYCLES=4, mask=5'b00001, no done -> dn_req high cycles 2..5, up_ack+up_err at 6, done_count unchanged; done at cycle 5 instead -> err=0.
- Mask=0 -> up_ack at cycle 1, err=0, done_count increments; spurious dn_done on unmasked child never affects state.
- Assert rst mid-WAIT with dn_req=5'b00111 -> all outputs 0 immediately, no up_ack; next up_req starts clean.
- done_count wrap with CNT_W=2: four error-free transactions -> 1,2,3,0; up_req held high during busy creates exactly one back-to-back follow-on transaction.
